// File: rtl/wsled_pixmem_arbiter.sv
// ---------------------------------------------------------------------------
// wsled_pixmem_arbiter
//
// Shares one pixel memory read port between four WSLED channel engines.
// The memory has a fixed two-cycle read latency. Each cycle a round-robin
// arbiter picks at most one requesting channel. It issues a registered read
// to the memory and tags the read with the channel number. When the data
// comes back, it strobes it to that channel.
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous, active-high reset
//   enable    1 allows new grants; reads already issued still complete
//   req       per-channel read request (level, held until granted)
//   addr      per-channel read address, channel i at [i*ADDR_W +: ADDR_W]
//   gnt       one-hot, one-cycle grant pulse (registered)
//   mem_rden  shared memory read enable
//   mem_addr  shared memory read address (holds when idle)
//   mem_q     memory read data, valid two cycles after mem_rden
//   rvalid    one-hot, one-cycle return strobe per channel
//   rdata     returned pixel word (GRB), held between strobes
//   busy      high while any grant or read is in flight
// ---------------------------------------------------------------------------
module wsled_pixmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   addr,
  output logic [3:0]            gnt,
  output logic                  mem_rden,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_q,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy
);

  // Last granted channel; the search starts one past it.
  logic [1:0] ptr;
  // Clears on reset and sets on the first edge after release. This keeps
  // the first grant off the first edge after reset is released.
  logic       armed;

  // Channel tag carried alongside the read through the memory latency.
  logic [1:0] gnt_ch;
  logic       t1_v;
  logic [1:0] t1_ch;
  logic       t2_v;
  logic [1:0] t2_ch;

  logic [3:0] eligible;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       found;

  // Round-robin search. A channel whose grant is showing this cycle is
  // excluded. Its requester is still updating req/addr in response to the
  // grant, so it must not be issued a second time.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    pick     = ptr;
    cand     = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    if (!enable || !armed) begin
      found = 1'b0;
    end
  end

  // Grant stage, two tag stages and the return register.
  // Data timing: mem_rden is high in cycle N+1, mem_q is valid in N+3,
  // and rvalid/rdata appear in N+4.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= 2'd3;
      armed    <= 1'b0;
      gnt      <= '0;
      gnt_ch   <= '0;
      mem_rden <= 1'b0;
      mem_addr <= '0;
      t1_v     <= 1'b0;
      t1_ch    <= '0;
      t2_v     <= 1'b0;
      t2_ch    <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      armed <= 1'b1;
      if (found) begin
        gnt      <= 4'b0001 << pick;
        gnt_ch   <= pick;
        mem_rden <= 1'b1;
        mem_addr <= addr[pick*ADDR_W +: ADDR_W];
        ptr      <= pick;
      end else begin
        gnt      <= '0;
        mem_rden <= 1'b0;
      end
      t1_v  <= mem_rden;
      t1_ch <= gnt_ch;
      t2_v  <= t1_v;
      t2_ch <= t1_ch;
      if (t2_v) begin
        rvalid <= 4'b0001 << t2_ch;
        rdata  <= mem_q;
      end else begin
        rvalid <= '0;
      end
    end
  end

  assign busy = mem_rden | t1_v | t2_v | (|rvalid);

endmodule

// File: tb/tb_wsled_pixmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wsled_pixmem_arbiter
//
// Directed bench for the pixel memory arbiter. It models a memory with
// two-cycle latency whose contents are a fixed function of the address.
// Each scenario task drives the DUT and compares the results against
// expected values worked out by hand.
// ---------------------------------------------------------------------------
module tb_wsled_pixmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic [3:0]      req = 4'b0000;
  logic [4*AW-1:0] addr = '0;
  logic [3:0]      gnt;
  logic            mem_rden;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_q = '0;
  logic [3:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_p1 = '0;

  wsled_pixmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .req      (req),
    .addr     (addr),
    .gnt      (gnt),
    .mem_rden (mem_rden),
    .mem_addr (mem_addr),
    .mem_q    (mem_q),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Contents of the pixel memory at a given address.
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return {a[7:0], ~a[7:0], 6'b000000, a[9:8]} ^ 24'h3C3C3C;
  endfunction

  // Memory with two-cycle read latency. A garbage word appears when no
  // read was issued.
  always @(posedge clk) begin
    mem_p1 <= mem_rden ? pix(mem_addr) : 24'hDEAD00;
    mem_q  <= mem_p1;
  end

  // Watchdog so that the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    addr[ch*AW +: AW] = a;
  endtask

  // Puts the DUT in reset and releases it, then lets the arming edge pass.
  task automatic do_reset();
    req    = 4'b0000;
    enable = 1'b1;
    addr   = '0;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    if (gnt !== 4'b0000 || mem_rden !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_gnt got %b/%b want 0000/0", gnt, mem_rden);
    end
    checks++;
    if (mem_addr !== '0 || rvalid !== 4'b0000 || rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h/%b/%h want 0/0/0", mem_addr, rvalid, rdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    reset = 1'b0;
    req   = 4'b1111;
    tick();
    if (gnt !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL first_edge_no_grant got %b want 0000", gnt);
    end
    checks++;
    tick();
    if (gnt !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL second_edge_grant got %b want 0001", gnt);
    end
    checks++;
    req = 4'b0000;
    repeat (6) tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    set_addr(2, 10'h155);
    tick();
    if (gnt !== 4'b0100 || mem_rden !== 1'b1 || mem_addr !== 10'h155) begin
      errors++;
      $display("[TB] FAIL single_issue got %b/%b/%h want 0100/1/155", gnt, mem_rden, mem_addr);
    end
    checks++;
    req = 4'b0000;
    tick();
    if (gnt !== 4'b0000 || mem_rden !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_idle got %b/%b/%b want 0000/0/1", gnt, mem_rden, busy);
    end
    checks++;
    tick();
    if (rvalid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_early_rvalid got %b want 0000", rvalid);
    end
    checks++;
    tick();
    if (rvalid !== 4'b0100 || rdata !== pix(10'h155)) begin
      errors++;
      $display("[TB] FAIL single_return got %b/%h want 0100/%h", rvalid, rdata, pix(10'h155));
    end
    checks++;
    tick();
    if (rvalid !== 4'b0000 || rdata !== pix(10'h155) || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_hold got %b/%h/%b want 0000/%h/0", rvalid, rdata, busy, pix(10'h155));
    end
    checks++;
    if (mem_addr !== 10'h155) begin
      errors++;
      $display("[TB] FAIL single_addr_hold got %h want 155", mem_addr);
    end
    checks++;
  endtask

  task automatic test_all_channels();
    logic [AW-1:0] cnt [4];
    logic [DW-1:0] exp_d [$];
    logic [1:0]    exp_c [$];
    logic [AW-1:0] a;
    logic [3:0]    want;
    int            strobes;
    do_reset();
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = '0;
      set_addr(i, AW'(i * 256));
    end
    req = 4'b1111;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (rvalid !== 4'b0000) begin
        strobes++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("[TB] FAIL all4_spurious_rvalid got %b want 0000", rvalid);
        end else begin
          want = 4'b0001 << exp_c[0];
          if (rvalid !== want || rdata !== exp_d[0]) begin
            errors++;
            $display("[TB] FAIL all4_return got %b/%h want %b/%h", rvalid, rdata, want, exp_d[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_c.pop_front());
        end
        checks++;
      end
      if (k < 16) begin
        want = 4'b0001 << (k % 4);
        a = AW'((k % 4) * 256) + cnt[k % 4];
        if (gnt !== want || mem_rden !== 1'b1 || mem_addr !== a) begin
          errors++;
          $display("[TB] FAIL all4_grant got %b/%b/%h want %b/1/%h", gnt, mem_rden, mem_addr, want, a);
        end
        checks++;
        exp_d.push_back(pix(a));
        exp_c.push_back(2'(k % 4));
        cnt[k % 4] = cnt[k % 4] + 1'b1;
        set_addr(k % 4, AW'((k % 4) * 256) + cnt[k % 4]);
      end
      if (k == 15) req = 4'b0000;
    end
    if (strobes != 16 || exp_d.size() != 0) begin
      errors++;
      $display("[TB] FAIL all4_count got %0d want 16", strobes);
    end
    checks++;
  endtask

  task automatic test_single_channel_hold();
    logic [AW-1:0] a;
    int            g;
    int            nact;
    do_reset();
    a    = 10'h040;
    g    = 0;
    nact = 0;
    set_addr(1, a);
    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt[1] === 1'b1) nact++;
      if (k % 2 == 0) begin
        if (gnt !== 4'b0010 || mem_addr !== a + AW'(g)) begin
          errors++;
          $display("[TB] FAIL ch1_grant got %b/%h want 0010/%h", gnt, mem_addr, a + AW'(g));
        end
        g++;
        set_addr(1, a + AW'(g));
      end else begin
        if (gnt !== 4'b0000 || mem_rden !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ch1_gap got %b/%b want 0000/0", gnt, mem_rden);
        end
      end
      checks++;
    end
    req = 4'b0000;
    if (nact != 5) begin
      errors++;
      $display("[TB] FAIL ch1_count got %0d want 5", nact);
    end
    checks++;
    repeat (5) tick();
  endtask

  task automatic test_enable_gap();
    logic [3:0]    want_v;
    logic [DW-1:0] want_d;
    do_reset();
    set_addr(0, 10'h010);
    set_addr(3, 10'h3F0);
    req = 4'b1001;
    tick();
    if (gnt !== 4'b0001 || mem_addr !== 10'h010) begin
      errors++;
      $display("[TB] FAIL en_first got %b/%h want 0001/010", gnt, mem_addr);
    end
    checks++;
    set_addr(0, 10'h011);
    tick();
    if (gnt !== 4'b1000 || mem_addr !== 10'h3F0) begin
      errors++;
      $display("[TB] FAIL en_second got %b/%h want 1000/3f0", gnt, mem_addr);
    end
    checks++;
    set_addr(3, 10'h3F1);
    enable = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      tick();
      want_v = (k == 4) ? 4'b0001 : (k == 5) ? 4'b1000 : 4'b0000;
      want_d = (k == 4) ? pix(10'h010) : pix(10'h3F0);
      if (gnt !== 4'b0000 || rvalid !== want_v || (want_v != 4'b0000 && rdata !== want_d)) begin
        errors++;
        $display("[TB] FAIL en_gap tick %0d got %b/%b/%h want 0000/%b/%h", k, gnt, rvalid, rdata, want_v, want_d);
      end
      checks++;
    end
    enable = 1'b1;
    tick();
    if (gnt !== 4'b0001 || mem_addr !== 10'h011) begin
      errors++;
      $display("[TB] FAIL en_resume0 got %b/%h want 0001/011", gnt, mem_addr);
    end
    checks++;
    tick();
    if (gnt !== 4'b1000 || mem_addr !== 10'h3F1) begin
      errors++;
      $display("[TB] FAIL en_resume3 got %b/%h want 1000/3f1", gnt, mem_addr);
    end
    checks++;
    req = 4'b0000;
    repeat (5) tick();
  endtask

  task automatic test_dropped_request();
    do_reset();
    enable = 1'b0;
    req = 4'b0100;
    set_addr(2, 10'h0AA);
    tick();
    tick();
    req = 4'b0000;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (gnt !== 4'b0000 || mem_rden !== 1'b0 || busy !== 1'b0 || mem_addr !== '0) begin
        errors++;
        $display("[TB] FAIL drop_no_grant got %b/%b/%b/%h want 0000/0/0/000", gnt, mem_rden, busy, mem_addr);
      end
      checks++;
    end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, AW'(i * 16 + 5));
    req = 4'b1111;
    tick();
    tick();
    if (gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL rif_pre got %b want 0010", gnt);
    end
    checks++;
    reset = 1'b1;
    #1;
    if (gnt !== 4'b0000 || mem_rden !== 1'b0 || mem_addr !== '0 || busy !== 1'b0 || rvalid !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL rif_async got %b/%b/%h/%b/%b want all zero", gnt, mem_rden, mem_addr, busy, rvalid);
    end
    checks++;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) begin
        if (gnt !== 4'b0001) begin
          errors++;
          $display("[TB] FAIL rif_first_grant got %b want 0001", gnt);
        end
        checks++;
        req = 4'b0000;
      end
      if (k < 5) begin
        if (rvalid !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL rif_stale_rvalid tick %0d got %b want 0000", k, rvalid);
        end
      end else begin
        if (rvalid !== 4'b0001 || rdata !== pix(10'h005)) begin
          errors++;
          $display("[TB] FAIL rif_return got %b/%h want 0001/%h", rvalid, rdata, pix(10'h005));
        end
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_single_channel_hold();
    test_enable_gap();
    test_dropped_request();
    test_reset_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wsled_pixmem_arbiter.md
WSLED_PIXMEM_ARBITER -- requirements
Module: wsled_pixmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the pixel memory word address width.
REQ-002 The block SHALL have parameter DATA_W, default 24, giving the pixel word width (GRB 8:8:8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: 1 allows new grants, 0 blocks them.
REQ-006 The block SHALL have port req, input, 4 bits: per-WSLED-channel read request, level, held until granted.
REQ-007 The block SHALL have port addr, input, 4*ADDR_W bits: per-channel read address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port gnt, output, 4 bits: one-cycle, one-hot grant pulse.
REQ-009 The block SHALL have port mem_rden, output, 1 bit: shared pixel memory read enable.
REQ-010 The block SHALL have port mem_addr, output, ADDR_W bits: shared pixel memory read address.
REQ-011 The block SHALL have port mem_q, input, DATA_W bits: memory read data, valid 2 cycles after mem_rden.
REQ-012 The block SHALL have port rvalid, output, 4 bits: one-hot, one-cycle return strobe per channel.
REQ-013 The block SHALL have port rdata, output, DATA_W bits: returned pixel word, qualified by rvalid.
REQ-014 The block SHALL have port busy, output, 1 bit: high while any grant or read is in flight.

Function
REQ-015 The block SHALL arbitrate round-robin once per cycle and issue at most one grant per cycle.
- Priority search starts at (last granted channel + 1) mod 4.
- The pointer wraps from 3 to 0.
- After reset the last granted channel is 3, so channel 0 has highest priority.
REQ-016 The block SHALL evaluate arbitration on cycle N and, on cycle N+1, present registered gnt[i]=1, mem_rden=1 and mem_addr = addr of channel i sampled on cycle N.
REQ-017 The block SHALL exclude channel i from arbitration in any cycle where gnt[i]=1, so a held request is never issued twice.
REQ-018 Requester obligation: on seeing gnt[i], the requester SHALL drop req[i] or present its next address in that same cycle.
REQ-019 The block SHALL keep mem_rden=0 and gnt=0 in any cycle with no eligible request; mem_addr then holds its last value.
REQ-020 The block SHALL carry a 2-stage channel-tag pipeline aligned with memory latency.
- mem_q is captured on cycle N+3.
- rvalid[i]=1 and rdata=mem_q on cycle N+4.
- Request-to-data latency is 4 cycles.
REQ-021 The block SHALL hold rdata between strobes; rvalid=0 in cycles with no return.
REQ-022 The block SHALL NOT grant on a cycle evaluated with enable=0.
- Reads already issued SHALL complete and return normally.
- Pending reqs are served once enable returns to 1, round-robin order preserved.
REQ-023 The block SHALL sustain full throughput of one read per cycle when 2 or more channels request continuously.
- Example: all 4 requesting gives grant order 0,1,2,3,0,... with mem_rden held at 1.
REQ-024 A single continuously requesting channel SHALL receive a grant every second cycle (a consequence of REQ-017).
REQ-025 busy SHALL equal OR(gnt-stage valid, tag stage 1 valid, tag stage 2 valid, any rvalid).
REQ-026 A req deasserted before grant SHALL be dropped with no grant and no side effect.

Reset
REQ-027 While reset=1, all of the following SHALL be 0 asynchronously and held: gnt, mem_rden, mem_addr, rvalid, rdata, busy, tag pipeline; the pointer SHALL be 3.
REQ-028 Reads in flight when reset asserts SHALL be discarded: no rvalid for them after reset releases.
REQ-029 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Verification
REQ-030 Single request: req=4'b0100, addr2=0x155 -> gnt=4'b0100, mem_rden=1, mem_addr=0x155 one cycle later; rvalid=4'b0100 with rdata=model value 4 cycles after req.
REQ-031 All 4 channels requesting continuously with distinct address streams for 16 cycles -> gnt sequence 0,1,2,3 repeating; mem_rden=1 every cycle after the first; 16 rvalid strobes, in order and data-correct.
REQ-032 Only channel 1 holding req for 10 cycles -> gnt[1] pulses on alternate cycles (5 grants); no duplicate mem_addr issues.
REQ-033 enable dropped for 6 cycles while channels 0 and 3 request, with 2 reads in flight -> those 2 rvalids still arrive; no gnt during the gap; after re-enable, grants resume at the pointer position.
REQ-034 reset pulsed 1 cycle after two grants -> outputs go to 0 immediately; no rvalid for the discarded reads; after release, channel 0 is granted first when all 4 request.
